// File: rtl/wheel_param_edit_if.sv
// Encoder/button pulses in, committed/displayed parameter and edit status out.
interface wheel_param_edit_if #(
   parameter int W = 12
);
   logic         r_tick;
   logic         l_tick;
   logic         key_tick;
   logic [W-1:0] param;
   logic [W-1:0] disp;
   logic         edit_active;
   logic         commit;
   logic         abort;

   modport master (
      output r_tick, l_tick, key_tick,
      input  param, disp, edit_active, commit, abort
   );

   modport slave (
      input  r_tick, l_tick, key_tick,
      output param, disp, edit_active, commit, abort
   );
endinterface

// File: rtl/wheel_param_edit.sv
// Rotary-wheel parameter editor: push to edit a shadow copy, rotate to adjust, push to commit.
// Optional rotation acceleration is enabled by defining WHEEL_PARAM_ACCEL_EN.
module wheel_param_edit #(
   parameter int           W          = 12,
   parameter logic [W-1:0] P_MIN      = 12'd1000,
   parameter logic [W-1:0] P_MAX      = 12'd2500,
   parameter logic [W-1:0] P_DEF      = 12'd2100,
   parameter int           TO_CYC     = 250_000_000,
   parameter int           ACCEL_WIN  = 5_000_000,
   parameter int           ACCEL_STEP = 10
) (
   input  logic                clk,
   input  logic                rst,
   wheel_param_edit_if.slave   bus
);

   localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EDIT = 1'b1
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    param_reg, param_next;
   logic [W-1:0]    shadow_reg, shadow_next;
   logic [W-1:0]    disp_reg, disp_next;
   logic [CW-1:0]   idle_cnt_reg, idle_cnt_next;
   logic            commit_reg, commit_next;
   logic            abort_reg, abort_next;

   logic            valid_tick;
   logic [W-1:0]    step;
   logic [W:0]      up_sum;
   logic [W:0]      dn_diff;

   // Opposing ticks in the same cycle cancel and do not count as activity.
   assign valid_tick = bus.r_tick ^ bus.l_tick;

`ifdef WHEEL_PARAM_ACCEL_EN
   localparam int GW = $clog2(ACCEL_WIN + 1);

   logic [GW-1:0]   gap_reg, gap_next;
   logic            last_dir_reg, last_dir_next;
   logic            have_prev_reg, have_prev_next;

   // gap_reg holds cycles since the previous valid tick minus one, saturating.
   always_comb begin
      step = W'(1);
      if (valid_tick && have_prev_reg && (bus.r_tick == last_dir_reg) &&
          (gap_reg < GW'(ACCEL_WIN - 1)))
         step = W'(ACCEL_STEP);
   end

   always_comb begin
      gap_next       = gap_reg;
      last_dir_next  = last_dir_reg;
      have_prev_next = have_prev_reg;
      if (gap_reg < GW'(ACCEL_WIN))
         gap_next = gap_reg + GW'(1);
      if (state_reg == IDLE) begin
         if (bus.key_tick)
            have_prev_next = 1'b0;
      end else if (!bus.key_tick && valid_tick) begin
         gap_next       = '0;
         last_dir_next  = bus.r_tick;
         have_prev_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gap_reg       <= '0;
         last_dir_reg  <= 1'b0;
         have_prev_reg <= 1'b0;
      end else begin
         gap_reg       <= gap_next;
         last_dir_reg  <= last_dir_next;
         have_prev_reg <= have_prev_next;
      end
   end
`else
   assign step = W'(1);
`endif

   // One extra bit keeps the saturation compares free of wrap-around.
   assign up_sum  = {1'b0, shadow_reg} + {1'b0, step};
   assign dn_diff = {1'b0, shadow_reg} - {1'b0, step};

   always_comb begin
      state_next    = state_reg;
      param_next    = param_reg;
      shadow_next   = shadow_reg;
      idle_cnt_next = idle_cnt_reg;
      commit_next   = 1'b0;
      abort_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.key_tick) begin
               state_next    = EDIT;
               shadow_next   = param_reg;
               idle_cnt_next = '0;
            end
         end
         EDIT: begin
            if (bus.key_tick) begin
               param_next  = shadow_reg;
               commit_next = 1'b1;
               state_next  = IDLE;
            end else if (valid_tick) begin
               idle_cnt_next = '0;
               if (bus.r_tick)
                  shadow_next = (up_sum > {1'b0, P_MAX}) ? P_MAX : up_sum[W-1:0];
               else
                  shadow_next = (dn_diff[W] || (dn_diff < {1'b0, P_MIN})) ?
                                P_MIN : dn_diff[W-1:0];
            end else if (idle_cnt_reg == CW'(TO_CYC - 1)) begin
               state_next    = IDLE;
               shadow_next   = param_reg;
               idle_cnt_next = '0;
               abort_next    = 1'b1;
            end else begin
               idle_cnt_next = idle_cnt_reg + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      disp_next = (state_next == EDIT) ? shadow_next : param_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         param_reg    <= P_DEF;
         shadow_reg   <= P_DEF;
         disp_reg     <= P_DEF;
         idle_cnt_reg <= '0;
         commit_reg   <= 1'b0;
         abort_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         param_reg    <= param_next;
         shadow_reg   <= shadow_next;
         disp_reg     <= disp_next;
         idle_cnt_reg <= idle_cnt_next;
         commit_reg   <= commit_next;
         abort_reg    <= abort_next;
      end
   end

   assign bus.param       = param_reg;
   assign bus.disp        = disp_reg;
   assign bus.edit_active = (state_reg == EDIT);
   assign bus.commit      = commit_reg;
   assign bus.abort       = abort_reg;

endmodule

// File: tb/tb_wheel_param_edit.sv
// Directed bench for wheel_param_edit; expected disp values flow through a scoreboard queue.
module tb_wheel_param_edit;
   localparam int W = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wheel_param_edit_if #(.W(W)) bus ();

   wheel_param_edit #(
      .W(W), .P_MIN(12'd1000), .P_MAX(12'd2500), .P_DEF(12'd2100),
      .TO_CYC(100), .ACCEL_WIN(10), .ACCEL_STEP(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Drive one cycle of pulses, then compare disp one clock later against the queued value.
   task automatic drive(input logic r, input logic l, input logic k,
                        input logic [W-1:0] exp_disp, input string tag);
      logic [W-1:0] want;
      exp_q.push_back(exp_disp);
      bus.r_tick   = r;
      bus.l_tick   = l;
      bus.key_tick = k;
      @(posedge clk); #1;
      bus.r_tick   = 1'b0;
      bus.l_tick   = 1'b0;
      bus.key_tick = 1'b0;
      want = exp_q.pop_front();
      $display("[TB] %s r=%0b l=%0b k=%0b disp=%0d param=%0d edit=%0b commit=%0b abort=%0b",
               tag, r, l, k, bus.disp, bus.param, bus.edit_active, bus.commit, bus.abort);
      check(tag, 32'(bus.disp), 32'(want));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_param", 32'(bus.param), 32'd2100);
      check("rst_disp", 32'(bus.disp), 32'd2100);
      check("rst_edit", 32'(bus.edit_active), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] mdl;
      logic [W-1:0] a1, a2, a3, a4;
      int n;

      rst = 1'b1;
      bus.r_tick = 1'b0; bus.l_tick = 1'b0; bus.key_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.key_tick = 1'b1;              // must be ignored while in reset
      @(posedge clk); #1;
      bus.key_tick = 1'b0;
      rst = 1'b0;
      check("reset_param", 32'(bus.param), 32'd2100);
      check("reset_disp", 32'(bus.disp), 32'd2100);
      check("reset_edit", 32'(bus.edit_active), 32'd0);
      check("reset_commit", 32'(bus.commit), 32'd0);
      check("reset_abort", 32'(bus.abort), 32'd0);

      // Basic edit and commit
      drive(0, 0, 1, 12'd2100, "enter_edit");
      check("edit_active", 32'(bus.edit_active), 32'd1);
      mdl = 12'd2100;
      for (int i = 0; i < 3; i++) begin
         mdl = mdl + 12'd1;
         drive(1, 0, 0, mdl, "r_tick");
         idle(19);
      end
      drive(0, 0, 1, 12'd2103, "commit");
      check("commit_pulse", 32'(bus.commit), 32'd1);
      check("commit_param", 32'(bus.param), 32'd2103);
      check("commit_edit", 32'(bus.edit_active), 32'd0);
      idle(1);
      check("commit_one_cycle", 32'(bus.commit), 32'd0);

      // Climb to 2498 with ticks spaced beyond the acceleration window
      drive(0, 0, 1, 12'd2103, "enter_edit");
      while (mdl < 12'd2498) begin
         mdl = mdl + 12'd1;
         drive(1, 0, 0, mdl, "climb");
         idle(11);
      end
      drive(0, 0, 1, 12'd2498, "commit");
      check("param_2498", 32'(bus.param), 32'd2498);

      // Upper saturation
      drive(0, 0, 1, 12'd2498, "enter_edit");
      for (int i = 0; i < 5; i++) begin
         mdl = (mdl + 12'd1 > 12'd2500) ? 12'd2500 : mdl + 12'd1;
         drive(1, 0, 0, mdl, "sat_hi");
         idle(19);
      end
      drive(0, 0, 1, 12'd2500, "commit");
      check("param_2500", 32'(bus.param), 32'd2500);
      do_reset();

      // Descend to 1001, then lower saturation
      mdl = 12'd2100;
      drive(0, 0, 1, mdl, "enter_edit");
      while (mdl > 12'd1001) begin
         mdl = mdl - 12'd1;
         drive(0, 1, 0, mdl, "descend");
         idle(11);
      end
      drive(0, 0, 1, 12'd1001, "commit");
      drive(0, 0, 1, 12'd1001, "enter_edit");
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 12'd1000, "sat_lo");
         idle(19);
      end
      drive(0, 0, 1, 12'd1000, "commit");
      check("param_1000", 32'(bus.param), 32'd1000);
      do_reset();

      // Inactivity timeout discards the edit
      drive(0, 0, 1, 12'd2100, "enter_edit");
      drive(1, 0, 0, 12'd2101, "r_tick");
      n = 201;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (bus.abort) begin
            n = i;
            break;
         end
      end
      $display("[TB] timeout abort after %0d quiet cycles", n);
      check("abort_latency", 32'(n), 32'd100);
      check("abort_param", 32'(bus.param), 32'd2100);
      check("abort_disp", 32'(bus.disp), 32'd2100);
      check("abort_edit", 32'(bus.edit_active), 32'd0);
      check("abort_no_commit", 32'(bus.commit), 32'd0);
      idle(1);
      check("abort_one_cycle", 32'(bus.abort), 32'd0);

      // Simultaneous ticks cancel; key wins over a coincident tick
      drive(0, 0, 1, 12'd2100, "enter_edit");
      drive(1, 0, 0, 12'd2101, "r_tick");
      drive(1, 1, 0, 12'd2101, "both_ticks");
      drive(1, 0, 1, 12'd2101, "key_with_r");
      check("key_wins_commit", 32'(bus.commit), 32'd1);
      check("key_wins_param", 32'(bus.param), 32'd2101);

      // Reset mid-edit
      mdl = 12'd2101;
      drive(0, 0, 1, mdl, "enter_edit");
      while (mdl < 12'd2150) begin
         mdl = mdl + 12'd1;
         drive(1, 0, 0, mdl, "to_2150");
         idle(11);
      end
      rst = 1'b1;
      bus.key_tick = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.key_tick = 1'b0;
      check("midrst_param", 32'(bus.param), 32'd2100);
      check("midrst_disp", 32'(bus.disp), 32'd2100);
      check("midrst_edit", 32'(bus.edit_active), 32'd0);
      check("midrst_commit", 32'(bus.commit), 32'd0);
      check("midrst_abort", 32'(bus.abort), 32'd0);

      // Rotation acceleration (ticks four cycles apart)
`ifdef WHEEL_PARAM_ACCEL_EN
      a1 = 12'd2101; a2 = 12'd2111; a3 = 12'd2121; a4 = 12'd2120;
`else
      a1 = 12'd2101; a2 = 12'd2102; a3 = 12'd2103; a4 = 12'd2102;
`endif
      drive(0, 0, 1, 12'd2100, "enter_edit");
      drive(1, 0, 0, a1, "accel_r1");
      idle(3);
      drive(1, 0, 0, a2, "accel_r2");
      idle(3);
      drive(1, 0, 0, a3, "accel_r3");
      idle(3);
      drive(0, 1, 0, a4, "accel_l1");
      drive(0, 0, 1, a4, "commit");
      check("accel_param", 32'(bus.param), 32'(a4));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/wheel_param_edit.md
WHEEL_PARAM_EDIT -- requirements
Module: wheel_param_edit

Interface
REQ-001 Parameter: W, 12, width of parameter value.
REQ-002 Parameter: P_MIN, 12'd1000, lower bound (wheel circumference, mm).
REQ-003 Parameter: P_MAX, 12'd2500, upper bound.
REQ-004 Parameter: P_DEF, 12'd2100, value loaded at reset.
REQ-005 Parameter: TO_CYC, 250_000_000, edit inactivity timeout in clk cycles (5 s at 50 MHz).
REQ-006 Parameter: ACCEL_WIN, 5_000_000, fast-rotation window in clk cycles.
REQ-007 Parameter: ACCEL_STEP, 10, step size when accelerated.
REQ-008 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-009 Port: rst  input  1  reset, synchronous, active-high.
REQ-010 Port: r_tick  input  1  one-cycle clockwise detent pulse from encoder stage.
REQ-011 Port: l_tick  input  1  one-cycle counter-clockwise detent pulse from encoder stage.
REQ-012 Port: key_tick  input  1  one-cycle debounced push-button press pulse.
REQ-013 Port: param  output  W  committed value, registered.
REQ-014 Port: disp  output  W  value to display: shadow while editing, else param; registered.
REQ-015 Port: edit_active  output  1  high in EDIT state.
REQ-016 Port: commit  output  1  one-cycle pulse when shadow written to param.
REQ-017 Port: abort  output  1  one-cycle pulse when edit discarded by timeout.

Function
REQ-018 FSM states IDLE, EDIT; edit_active = (state==EDIT).
REQ-019 IDLE: r_tick/l_tick ignored; key_tick -> EDIT next cycle, shadow <= param, idle counter cleared.
REQ-020 EDIT, r_tick only: shadow <= min(shadow+step, P_MAX); no wrap-around.
REQ-021 EDIT, l_tick only: shadow <= max(shadow-step, P_MIN); no wrap-around; arithmetic done in W+1 bits to avoid underflow.
REQ-022 EDIT, r_tick and l_tick same cycle: shadow unchanged, not counted as activity.
REQ-023 EDIT, key_tick: param <= shadow, commit=1 for one cycle, -> IDLE; any coincident tick ignored (key wins).
REQ-024 EDIT idle counter increments each cycle without a valid tick, clears on valid tick; reaching TO_CYC-1 -> IDLE, shadow discarded, param unchanged, abort=1 one cycle.
REQ-025 Timeout and key_tick same cycle: key wins (commit, no abort).
REQ-026 commit and abort never high together; each high at most one cycle per EDIT exit.
REQ-027 disp updates one cycle after the causing input; latency of all outputs is exactly one clock.
REQ-028 step = 1 unless acceleration active (REQ-033).

Reset
REQ-029 rst high at any clock edge, including mid-edit: state IDLE, param=P_DEF, disp=P_DEF, shadow=P_DEF, counters 0, edit_active=0, commit=0, abort=0.
REQ-030 Inputs during rst cycle are ignored.
REQ-031 P_MIN <= P_DEF <= P_MAX is a parameter legality requirement; behaviour otherwise undefined.

Configuration
REQ-032 Macro WHEEL_PARAM_ACCEL_EN selects rotation acceleration.
REQ-033 Defined: in EDIT, a valid tick arriving fewer than ACCEL_WIN cycles after the previous valid tick in the same direction uses step=ACCEL_STEP; direction change, first tick after entering EDIT, or gap >= ACCEL_WIN uses step=1; saturation per REQ-020/021 still applies.
REQ-034 Not defined: step always 1; gap counter and last-direction register not synthesized.

Verification (bench overrides TO_CYC=100, ACCEL_WIN=10)
REQ-035 rst, then key_tick, 3x r_tick 20 cycles apart, key_tick -> param=2103, commit one cycle, edit_active 0.
REQ-036 Edit from 2498, 5x r_tick spaced 20 -> disp saturates 2500; from 1001, 3x l_tick -> disp 1000, no wrap.
REQ-037 key_tick, 1x r_tick, then 100 quiet cycles -> abort one cycle, param stays 2100, disp returns 2100.
REQ-038 In EDIT, r_tick and l_tick same cycle -> disp unchanged; key_tick with r_tick same cycle -> commit of pre-tick shadow.
REQ-039 WHEEL_PARAM_ACCEL_EN defined: r_tick x3 spaced 4 cycles from 2100 -> disp 2101, 2111, 2121; then l_tick after 4 cycles -> 2120; without macro same stimulus -> 2103 then 2102.
REQ-040 rst asserted mid-edit with shadow 2150 -> next cycle param=2100, edit_active 0, no commit/abort pulse.
